// File: rtl/viterbi_channel_injector.sv
// viterbi_channel_injector: channel model between convolutional encoder and Viterbi decoder.
// Delays coded symbols by one cycle and XORs cfg_mask into selected symbols
// (bypass, periodic burst, Galois-LFSR random, or single-shot), keeping statistics.
// Ports:
//   clk, rst (async, active-low)
//   start/stop          run control pulses; start latches cfg_*, clears stats
//   cfg_mode            0 bypass, 1 burst, 2 random, 3 single-shot
//   cfg_mask            bits inverted in a corrupted symbol
//   cfg_period          burst period / single-shot symbol index
//   cfg_burst_len       burst: corrupted symbols at the end of each period
//   cfg_thresh          random: corrupt when lfsr < cfg_thresh
//   cfg_window          symbols per run, 0 = unlimited
//   valid_i, sym_i      encoder symbol stream
//   valid_o, sym_o      delayed (and possibly corrupted) stream, err_o flags corruption
//   busy_o              high while running
//   sym_cnt_o, err_sym_cnt_o, err_bit_cnt_o   saturating statistics
module viterbi_channel_injector #(
    parameter int                 SYM_W     = 2,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        cfg_mode,
    input  logic [SYM_W-1:0]  cfg_mask,
    input  logic [15:0]       cfg_period,
    input  logic [15:0]       cfg_burst_len,
    input  logic [LFSR_W-1:0] cfg_thresh,
    input  logic [CNT_W-1:0]  cfg_window,
    input  logic              valid_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic              valid_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  sym_cnt_o,
    output logic [CNT_W-1:0]  err_sym_cnt_o,
    output logic [CNT_W-1:0]  err_bit_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

    state_t              r_state, w_next;
    logic [1:0]          r_mode;
    logic [SYM_W-1:0]    r_mask;
    logic [15:0]         r_period, r_blen, r_phase;
    logic [LFSR_W-1:0]   r_thresh, r_lfsr;
    logic [CNT_W-1:0]    r_window, r_sym_cnt, r_err_sym, r_err_bit;
    logic                r_valid, r_err;
    logic [SYM_W-1:0]    r_sym;

    logic                w_act, w_hit, w_inj, w_shot, w_win_hit;
    logic [15:0]         w_p, w_b, w_phase_nxt;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic [CNT_W-1:0]    w_sym_nxt, w_err_sym_nxt, w_err_bit_nxt;
    logic [CNT_W:0]      w_bit_sum;

    // Mode 0 is a pure wire: no pattern advance and no statistics
    assign w_act         = (r_state == S_RUN) && valid_i && (r_mode != 2'd0);
    assign w_p           = (r_period == 16'd0) ? 16'd1 : r_period;
    assign w_b           = (r_blen > w_p) ? w_p : r_blen;
    assign w_inj         = w_act && w_hit;
    assign w_shot        = w_inj && (r_mode == 2'd3);
    assign w_phase_nxt   = (r_mode == 2'd1 && r_phase == w_p - 16'd1) ? 16'd0 : r_phase + 16'd1;
    assign w_lfsr_nxt    = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    assign w_sym_nxt     = &r_sym_cnt ? r_sym_cnt : r_sym_cnt + 1'b1;
    assign w_err_sym_nxt = &r_err_sym ? r_err_sym : r_err_sym + 1'b1;
    assign w_bit_sum     = {1'b0, r_err_bit} + (CNT_W+1)'($countones(r_mask));
    assign w_err_bit_nxt = w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
    assign w_win_hit     = w_act && (r_window != '0) && (w_sym_nxt == r_window);

    always_comb begin
        w_hit = 1'b0;
        case (r_mode)
            2'd1:    w_hit = r_phase >= w_p - w_b;
            2'd2:    w_hit = r_lfsr < r_thresh;
            2'd3:    w_hit = r_phase == r_period;
            default: w_hit = 1'b0;
        endcase
    end

    // start has priority over stop and every run-ending condition
    always_comb begin
        w_next = r_state;
        if (start)
            w_next = S_RUN;
        else if (r_state == S_RUN && (stop || w_win_hit || w_shot))
            w_next = S_DONE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_sym     <= '0;
            r_err     <= 1'b0;
            r_mode    <= '0;
            r_mask    <= '0;
            r_period  <= '0;
            r_blen    <= '0;
            r_thresh  <= '0;
            r_window  <= '0;
            r_phase   <= '0;
            r_lfsr    <= LFSR_SEED;
            r_sym_cnt <= '0;
            r_err_sym <= '0;
            r_err_bit <= '0;
        end else begin
            r_valid <= valid_i;
            r_sym   <= sym_i ^ (w_inj ? r_mask : '0);
            r_err   <= w_inj;
            if (start) begin
                r_mode    <= cfg_mode;
                r_mask    <= cfg_mask;
                r_period  <= cfg_period;
                r_blen    <= cfg_burst_len;
                r_thresh  <= cfg_thresh;
                r_window  <= cfg_window;
                r_phase   <= '0;
                r_lfsr    <= LFSR_SEED;
                r_sym_cnt <= '0;
                r_err_sym <= '0;
                r_err_bit <= '0;
            end else if (w_act) begin
                r_phase   <= w_phase_nxt;
                r_lfsr    <= w_lfsr_nxt;
                r_sym_cnt <= w_sym_nxt;
                if (w_inj) begin
                    r_err_sym <= w_err_sym_nxt;
                    r_err_bit <= w_err_bit_nxt;
                end
            end
        end
    end

    assign valid_o       = r_valid;
    assign sym_o         = r_sym;
    assign err_o         = r_err;
    assign busy_o        = (r_state == S_RUN);
    assign sym_cnt_o     = r_sym_cnt;
    assign err_sym_cnt_o = r_err_sym;
    assign err_bit_cnt_o = r_err_bit;
endmodule

// File: tb/tb_viterbi_channel_injector.sv
// tb_viterbi_channel_injector: scoreboard bench for the channel injector.
module tb_viterbi_channel_injector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [1:0]  cfg_mask = '0;
    logic [15:0] cfg_period = '0, cfg_burst_len = '0, cfg_thresh = '0;
    logic [31:0] cfg_window = '0;
    logic        valid_i = 1'b0;
    logic [1:0]  sym_i = '0;
    logic        valid_o, err_o, busy_o;
    logic [1:0]  sym_o;
    logic [31:0] sym_cnt_o, err_sym_cnt_o, err_bit_cnt_o;

    int          tests = 0, fails = 0;
    logic [2:0]  q[$];
    logic [2:0]  m_exp;
    int          n1, n2;

    viterbi_channel_injector dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .cfg_period(cfg_period),
        .cfg_burst_len(cfg_burst_len), .cfg_thresh(cfg_thresh), .cfg_window(cfg_window),
        .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
        .busy_o(busy_o), .sym_cnt_o(sym_cnt_o), .err_sym_cnt_o(err_sym_cnt_o),
        .err_bit_cnt_o(err_bit_cnt_o)
    );

    always #5 clk = ~clk;

    // Monitor: every valid output must match the oldest expected {err, sym}
    always @(negedge clk) begin
        if (rst && valid_o) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got err=%0d sym=%0d, expected no output", err_o, sym_o);
            end else begin
                m_exp = q.pop_front();
                if ({err_o, sym_o} !== m_exp) begin
                    fails++;
                    $display("FAIL scoreboard: got err=%0d sym=%0d, expected err=%0d sym=%0d",
                             err_o, sym_o, m_exp[2], m_exp[1:0]);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, a, x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input bit e, input logic [1:0] m);
        valid_i = 1'b1;
        sym_i   = s;
        q.push_back({e, e ? (s ^ m) : s});
        tick();
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic go(input logic [1:0] md, input logic [1:0] mk, input logic [15:0] per,
                      input logic [15:0] bl, input logic [15:0] th, input logic [31:0] win,
                      input bit with_stop);
        cfg_mode = md; cfg_mask = mk; cfg_period = per;
        cfg_burst_len = bl; cfg_thresh = th; cfg_window = win;
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        // scramble cfg to prove it is latched, not live
        cfg_mode = ~md; cfg_mask = ~mk; cfg_period = ~per; cfg_thresh = ~th;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // 100 random-mode symbols checked against a reference Galois LFSR
    task automatic run_rand100(output int ne);
        logic [15:0] lf;
        bit e;
        lf = 16'hACE1;
        ne = 0;
        for (int i = 0; i < 100; i++) begin
            e = lf < 16'h4000;
            ne += int'(e);
            send(2'(i), e, 2'b01);
            lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    initial begin
        logic [15:0] lf;
        bit e;
        int ne;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_sym_o", 32'(sym_o), 0);
        chk("rst_err_o", 32'(err_o), 0);
        chk("rst_busy_o", 32'(busy_o), 0);
        chk("rst_sym_cnt", sym_cnt_o, 0);
        chk("rst_err_bit", err_bit_cnt_o, 0);
        rst = 1'b1;
        idle(2);

        // T1 bypass
        go(2'd0, 2'b11, 16'd3, 16'd1, 16'hFFFF, 32'd0, 1'b0);
        chk("t1_busy", 32'(busy_o), 1);
        for (int i = 0; i < 64; i++) send(2'($urandom), 1'b0, 2'b11);
        idle(1);
        chk("t1_sym_cnt", sym_cnt_o, 0);
        chk("t1_err_sym", err_sym_cnt_o, 0);
        chk("t1_err_bit", err_bit_cnt_o, 0);
        halt();
        chk("t1_stopped", 32'(busy_o), 0);

        // T2 burst P=16 B=4 over a 256-symbol window
        go(2'd1, 2'b01, 16'd16, 16'd4, 16'd0, 32'd256, 1'b0);
        for (int i = 0; i < 256; i++) send(2'(i * 3), (i % 16) >= 12, 2'b01);
        chk("t2_done", 32'(busy_o), 0);
        chk("t2_sym_cnt", sym_cnt_o, 256);
        chk("t2_err_sym", err_sym_cnt_o, 64);
        chk("t2_err_bit", err_bit_cnt_o, 64);
        for (int i = 0; i < 4; i++) send(2'(i), 1'b0, 2'b01);
        chk("t2_hold_sym_cnt", sym_cnt_o, 256);

        // T3 random
        go(2'd2, 2'b11, 16'd0, 16'd0, 16'h1000, 32'd0, 1'b0);
        lf = 16'hACE1;
        ne = 0;
        for (int i = 0; i < 4096; i++) begin
            e = lf < 16'h1000;
            ne += int'(e);
            send(2'(i), e, 2'b11);
            lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
        end
        chk("t3_sym_cnt", sym_cnt_o, 4096);
        chk("t3_err_sym", err_sym_cnt_o, 32'(ne));
        chk("t3_err_bit", err_bit_cnt_o, 32'(2 * ne));
        halt();

        // T4 single-shot with gaps: only the 6th valid symbol
        go(2'd3, 2'b10, 16'd5, 16'd0, 16'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(2'(i), i == 5, 2'b10);
            if (i == 4) chk("t4_busy_before", 32'(busy_o), 1);
            if (i == 5) chk("t4_busy_after", 32'(busy_o), 0);
            idle(1);
        end
        chk("t4_sym_cnt", sym_cnt_o, 6);
        chk("t4_err_sym", err_sym_cnt_o, 1);
        chk("t4_err_bit", err_bit_cnt_o, 1);

        // T5a P=0 B=3: every symbol, window 8
        go(2'd1, 2'b11, 16'd0, 16'd3, 16'd0, 32'd8, 1'b0);
        for (int i = 0; i < 8; i++) send(2'(i), 1'b1, 2'b11);
        chk("t5a_done", 32'(busy_o), 0);
        chk("t5a_err_sym", err_sym_cnt_o, 8);
        chk("t5a_err_bit", err_bit_cnt_o, 16);

        // T5b burst_len=0: no errors
        go(2'd1, 2'b11, 16'd8, 16'd0, 16'd0, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++) send(2'(i), 1'b0, 2'b11);
        chk("t5b_err_sym", err_sym_cnt_o, 0);
        chk("t5b_busy", 32'(busy_o), 1);

        // T5c restart mid-run resets counters and phase
        go(2'd1, 2'b01, 16'd4, 16'd1, 16'd0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) send(2'(i), (i % 4) == 3, 2'b01);
        chk("t5c_err_sym_pre", err_sym_cnt_o, 1);
        go(2'd1, 2'b01, 16'd4, 16'd1, 16'd0, 32'd0, 1'b0);
        chk("t5c_sym_cnt_clr", sym_cnt_o, 0);
        chk("t5c_err_sym_clr", err_sym_cnt_o, 0);
        for (int i = 0; i < 4; i++) send(2'(i), i == 3, 2'b01);
        chk("t5c_sym_cnt", sym_cnt_o, 4);
        chk("t5c_err_sym", err_sym_cnt_o, 1);

        // T5d start+stop together: start wins
        go(2'd1, 2'b01, 16'd4, 16'd1, 16'd0, 32'd0, 1'b1);
        chk("t5d_busy", 32'(busy_o), 1);
        halt();
        chk("t5d_stopped", 32'(busy_o), 0);

        // T6 reset mid-run, then identical rerun from the seed
        go(2'd2, 2'b01, 16'd0, 16'd0, 16'h4000, 32'd0, 1'b0);
        run_rand100(n1);
        chk("t6_err_sym_run1", err_sym_cnt_o, 32'(n1));
        idle(1);
        valid_i = 1'b1;
        sym_i   = 2'b11;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_valid_o", 32'(valid_o), 0);
        chk("t6_rst_sym_o", 32'(sym_o), 0);
        chk("t6_rst_busy", 32'(busy_o), 0);
        chk("t6_rst_sym_cnt", sym_cnt_o, 0);
        valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        go(2'd2, 2'b01, 16'd0, 16'd0, 16'h4000, 32'd0, 1'b0);
        run_rand100(n2);
        chk("t6_sym_cnt_run2", sym_cnt_o, 100);
        chk("t6_err_sym_run2", err_sym_cnt_o, 32'(n1));
        halt();

        idle(3);
        chk("queue_drain", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
